vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters: none; all geometry comes from shared constants (SCREEN_WIDTH=160, SCREEN_HEIGHT=120, COLOUR_WIDTH=3, FB_ADDR_WIDTH=15).
REQ-002 clock  input  1  pixel clock, 25 MHz, rising edge.
REQ-003 resetn  input  1  reset: synchronous, active-low.
REQ-004 rd_addr  output  FB_ADDR_WIDTH  framebuffer read address.
REQ-005 rd_data  input  COLOUR_WIDTH  framebuffer read data, valid exactly 1 cycle after rd_addr.
REQ-006 vga_colour  output  COLOUR_WIDTH  pixel colour to DAC.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 blank_n  output  1  high in visible region only.
REQ-010 frame_start  output  1  single-cycle pulse at start of vertical blank; drives drawer start.

Function
REQ-011 h_cnt counts 0..799 and wraps to 0; v_cnt increments when h_cnt wraps, counts 0..524, wraps to 0.
REQ-012 Visible region SHALL be h_cnt<640 and v_cnt<480.
REQ-013 hsync SHALL be low for h_cnt 656..751; vsync low for v_cnt 490..491; otherwise high.
REQ-014 Framebuffer coordinates: fb_x=h_cnt[9:2], fb_y=v_cnt[8:2] (4x upscale, 160x120 to 640x480).
REQ-015 rd_addr SHALL be registered: fb_y*160+fb_x of the current counters, updated every cycle; in blanking, rd_addr holds 0.
REQ-016 Pipeline: hsync, vsync, blank_n and vga_colour SHALL reflect the counter value from exactly 2 cycles earlier (stage 1: address; stage 2: data capture).
REQ-017 vga_colour SHALL equal rd_data when the delayed blank_n is 1, else 0.
REQ-018 frame_start SHALL be 1 for exactly one cycle, 1 cycle after counters equal (h=0, v=480); this gives 36000 blanking cycles, enough for a 19200-pixel redraw.
REQ-019 No backpressure or handshake on rd_data; the memory is assumed always ready with 1-cycle latency.

Reset
REQ-020 While resetn=0: h_cnt=0, v_cnt=0, rd_addr=0, vga_colour=0, hsync=1, vsync=1, blank_n=0, frame_start=0, pipeline stages cleared.
REQ-021 Reset mid-frame SHALL abandon the frame; the first cycle after release has counters (0,0); the first visible pixel appears on the outputs 2 cycles later.

Configuration
REQ-022 Macro SCANOUT_BORDER_EN: when defined, visible pixels with h_cnt in {0,639} or v_cnt in {0,479} output all-ones colour instead of rd_data (1-pixel white frame for monitor alignment); when undefined, rd_data is passed unchanged.
REQ-023 The macro SHALL NOT change timing, latency or any other output.

Structure
REQ-024 SCREEN_WIDTH, SCREEN_HEIGHT, COLOUR_WIDTH, FB_ADDR_WIDTH and all VGA timing constants (H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48, V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_BACK=33) SHALL live in the shared constants package.
REQ-025 A sub-module vga_timing_counter SHALL hold h_cnt/v_cnt and the raw sync/visible decode; vga_scanout adds the addressing, pipeline alignment and frame_start.

Verification
REQ-026 Reset held 5 cycles, then released -> outputs at reset values throughout; counters at (0,0) on first cycle after release.
REQ-027 Free-run 2 frames -> hsync low 96 cycles per 800-cycle line; vsync low 1600 cycles per 420000-cycle frame; blank_n high 640 cycles per visible line.
REQ-028 Memory model returns rd_data = rd_addr[2:0] -> at counters (h=8,v=4), rd_addr=162; vga_colour=2 two cycles later.
REQ-029 Counters reach (0,480) -> frame_start=1 on the next cycle only; exactly one pulse per frame.
REQ-030 Assert resetn=0 at (h=300,v=200) for 1 cycle -> outputs return to reset values, then restart at (0,0) with no partial-line glitch.
REQ-031 SCANOUT_BORDER_EN defined, rd_data=0 -> vga_colour=3'b111 at pixels (0,y), (639,y), (x,0), (x,479); 0 elsewhere; undefined -> 0 everywhere.

Source files
------------

// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg
//   Shared constants for the 160x120 framebuffer scanout: screen geometry,
//   colour/address widths and 640x480@60 VGA timing. Also holds the typed
//   counter compare points and the framebuffer address helper.
//   Imported by vga_timing_counter and vga_scanout.
package vga_scanout_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int COLOUR_WIDTH  = 3;
  localparam int FB_ADDR_WIDTH = 15;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  localparam int CNT_WIDTH = 10;
  typedef logic [CNT_WIDTH-1:0]     cnt_t;
  typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

  // Counter compare points, pre-sized to the counter width.
  localparam cnt_t H_LAST      = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST      = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS_LIMIT = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS_LIMIT = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_FIRST    = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_LAST     = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST    = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_LAST     = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam cnt_t H_EDGE      = cnt_t'(H_VISIBLE - 1);
  localparam cnt_t V_EDGE      = cnt_t'(V_VISIBLE - 1);
  localparam cnt_t FS_LINE     = cnt_t'(V_VISIBLE);

  // Control bits carried alongside the pixel through the read pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } sync_stage_t;

  localparam sync_stage_t SYNC_STAGE_RESET = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

  // Linear framebuffer address of a 160x120 pixel.
  function automatic fb_addr_t fb_addr(input logic [7:0] fb_x, input logic [6:0] fb_y);
    fb_addr_t x_ext;
    fb_addr_t y_ext;
    x_ext = fb_addr_t'(fb_x);
    y_ext = fb_addr_t'(fb_y);
    return y_ext * fb_addr_t'(SCREEN_WIDTH) + x_ext;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter
//   Free-running 800x525 pixel/line counters with raw (undelayed) decode of
//   the sync pulses and the visible window.
//   Ports:
//     clock      in   pixel clock
//     resetn     in   synchronous active-low reset, counters to (0,0)
//     h_cnt      out  horizontal position 0..799
//     v_cnt      out  line number 0..524
//     visible    out  h_cnt<640 and v_cnt<480
//     hsync_raw  out  active-low, low for h_cnt 656..751
//     vsync_raw  out  active-low, low for v_cnt 490..491
module vga_timing_counter
  import vga_scanout_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic visible,
  output logic hsync_raw,
  output logic vsync_raw
);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + cnt_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign visible   = (h_cnt_q < H_VIS_LIMIT) && (v_cnt_q < V_VIS_LIMIT);
  assign hsync_raw = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
  assign vsync_raw = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
//   Scans a 160x120 framebuffer out as 640x480@60 VGA with 4x pixel
//   replication. Two-stage pipeline: stage 1 registers the read address,
//   stage 2 lines the sync/blank flags up with the returning read data.
//   Ports:
//     clock        in   25 MHz pixel clock
//     resetn       in   synchronous active-low reset
//     rd_addr      out  framebuffer read address (0 during blanking)
//     rd_data      in   framebuffer data, one cycle after rd_addr
//     vga_colour   out  pixel colour to the DAC (0 outside the visible area)
//     hsync/vsync  out  active-low sync pulses
//     blank_n      out  high for visible pixels
//     frame_start  out  one-cycle pulse at the start of vertical blanking
//   Build option: define SCANOUT_BORDER_EN to paint a 1-pixel all-ones
//   border around the visible area (no effect on timing or other outputs).
module vga_scanout
  import vga_scanout_pkg::*;
(
  input  logic                     clock,
  input  logic                     resetn,
  output logic [FB_ADDR_WIDTH-1:0] rd_addr,
  input  logic [COLOUR_WIDTH-1:0]  rd_data,
  output logic [COLOUR_WIDTH-1:0]  vga_colour,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     blank_n,
  output logic                     frame_start
);

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic visible;
  logic hsync_raw;
  logic vsync_raw;

  vga_timing_counter u_timing (
    .clock     (clock),
    .resetn    (resetn),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  fb_addr_t    rd_addr_q, rd_addr_d;
  sync_stage_t sync1_q, sync1_d;
  sync_stage_t sync2_q, sync2_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    rd_addr_d     = visible ? fb_addr(h_cnt[9:2], v_cnt[8:2]) : '0;
    sync1_d       = '{hsync: hsync_raw, vsync: vsync_raw, blank_n: visible};
    sync2_d       = sync1_q;
    // Pulse the cycle after the counters enter the first blanking line.
    frame_start_d = (h_cnt == '0) && (v_cnt == FS_LINE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_addr_q     <= '0;
      sync1_q       <= SYNC_STAGE_RESET;
      sync2_q       <= SYNC_STAGE_RESET;
      frame_start_q <= 1'b0;
    end else begin
      rd_addr_q     <= rd_addr_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef SCANOUT_BORDER_EN
  // Border flag rides the same two stages as blank_n.
  logic border1_q, border1_d;
  logic border2_q, border2_d;

  always_comb begin
    border1_d = visible && ((h_cnt == '0) || (h_cnt == H_EDGE) ||
                            (v_cnt == '0) || (v_cnt == V_EDGE));
    border2_d = border1_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      border1_q <= 1'b0;
      border2_q <= 1'b0;
    end else begin
      border1_q <= border1_d;
      border2_q <= border2_d;
    end
  end

  assign vga_colour = !sync2_q.blank_n ? '0 : (border2_q ? '1 : rd_data);
`else
  assign vga_colour = sync2_q.blank_n ? rd_data : '0;
`endif

  assign rd_addr     = rd_addr_q;
  assign hsync       = sync2_q.hsync;
  assign vsync       = sync2_q.vsync;
  assign blank_n     = sync2_q.blank_n;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Randomised scoreboard bench for vga_scanout. A driver process issues
//   resets and counter jumps, steps a cycle-level reference model built from
//   the VGA timing rules and pushes the expected outputs of each cycle into a
//   queue; a monitor process pops and compares on the opposite clock edge.
//   The framebuffer is a 1-cycle-latency memory filled with random colours.
module tb_vga_scanout;
  import vga_scanout_pkg::*;

  logic                     clock = 1'b0;
  logic                     resetn = 1'b0;
  logic [FB_ADDR_WIDTH-1:0] rd_addr;
  logic [COLOUR_WIDTH-1:0]  rd_data = '0;
  logic [COLOUR_WIDTH-1:0]  vga_colour;
  logic                     hsync;
  logic                     vsync;
  logic                     blank_n;
  logic                     frame_start;

  vga_scanout dut (
    .clock       (clock),
    .resetn      (resetn),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .vga_colour  (vga_colour),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .frame_start (frame_start)
  );

  always #20 clock = ~clock;

  logic [COLOUR_WIDTH-1:0] fb_mem [0:19199];

  always @(posedge clock) rd_data <= fb_mem[rd_addr];

  typedef struct {
    int addr;
    int colour;
    int hs;
    int vs;
    int bl;
    int fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   count_en = 1'b0;
  int   fs_count = 0;
  int   vs_low = 0;

  // Reference model: counter value during the current (0), previous (1) and
  // one-before-previous (2) cycle, plus whether reset hit the last two edges.
  int m_h0 = 0, m_v0 = 0, m_h1 = 0, m_v1 = 0, m_h2 = 0, m_v2 = 0;
  bit m_rst_cur = 1'b1, m_rst_prev = 1'b1;
  logic [9:0] jump_h = '0;
  logic [9:0] jump_v = '0;

  function automatic bit in_view(int h, int v);
    return (h < 640) && (v < 480);
  endfunction

  function automatic int pixel(int h, int v);
    int a = (v / 4) * 160 + h / 4;
`ifdef SCANOUT_BORDER_EN
    if (h == 0 || h == 639 || v == 0 || v == 479) return 7;
`endif
    return int'(fb_mem[a]);
  endfunction

  function automatic void check(string name, int cyc, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endfunction

  task automatic tick(input bit rst, input bit do_jump);
    exp_t e;
    @(negedge clock);
    if (do_jump) begin
      force dut.u_timing.h_cnt_q = jump_h;
      force dut.u_timing.v_cnt_q = jump_v;
      release dut.u_timing.h_cnt_q;
      release dut.u_timing.v_cnt_q;
      m_h0 = int'(jump_h);
      m_v0 = int'(jump_v);
    end
    resetn = !rst;
    @(posedge clock);
    #1;
    m_h2 = m_h1; m_v2 = m_v1;
    m_h1 = m_h0; m_v1 = m_v0;
    m_rst_prev = m_rst_cur;
    m_rst_cur  = rst;
    if (rst) begin
      m_h0 = 0;
      m_v0 = 0;
    end else begin
      m_h0 = (m_h1 + 1) % 800;
      m_v0 = (m_h1 == 799) ? (m_v1 + 1) % 525 : m_v1;
    end
    e = '{addr: 0, colour: 0, hs: 1, vs: 1, bl: 0, fs: 0};
    if (!m_rst_cur) begin
      if (in_view(m_h1, m_v1)) e.addr = (m_v1 / 4) * 160 + m_h1 / 4;
      e.fs = (m_h1 == 0 && m_v1 == 480) ? 1 : 0;
      if (!m_rst_prev) begin
        e.hs = (m_h2 >= 656 && m_h2 <= 751) ? 0 : 1;
        e.vs = (m_v2 >= 490 && m_v2 <= 491) ? 0 : 1;
        e.bl = in_view(m_h2, m_v2) ? 1 : 0;
        if (e.bl == 1) e.colour = pixel(m_h2, m_v2);
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        check("rd_addr", cyc, int'(rd_addr), e.addr);
        check("vga_colour", cyc, int'(vga_colour), e.colour);
        check("hsync", cyc, int'(hsync), e.hs);
        check("vsync", cyc, int'(vsync), e.vs);
        check("blank_n", cyc, int'(blank_n), e.bl);
        check("frame_start", cyc, int'(frame_start), e.fs);
        if (count_en) begin
          if (frame_start) fs_count++;
          if (!vsync) vs_low++;
        end
      end
    end
  end

  initial begin : driver
    int r1, r2;
    for (int i = 0; i < 19200; i++) fb_mem[i] = 3'($urandom_range(0, 7));
    r1 = $urandom_range(500, 1500);
    r2 = $urandom_range(1800, 3000);

    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    $display("phase reset: 5 cycles held");

    for (int i = 0; i < 3300; i++) tick((i == r1) || (i == r2) || (i == r2 + 1), 1'b0);
    $display("phase lines: 3300 cycles, resets at %0d and %0d", r1, r2);

    jump_h = 10'd296;
    jump_v = 10'd200;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 1700; i++) tick(1'b0, 1'b0);
    $display("phase midframe reset: 1-cycle reset at (300,200)");

    jump_h = 10'd790;
    jump_v = 10'd476;
    count_en = 1'b1;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 40000; i++) tick(1'b0, 1'b0);
    @(negedge clock);
    #1;
    count_en = 1'b0;
    $display("phase frame boundary: 40000 cycles from (790,476)");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    check("frame_start_pulses", -1, fs_count, 1);
    check("vsync_low_cycles", -1, vs_low, 1600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
